// File: rtl/ysyx_22040759_mdu_ctrl.sv
// Iterative RV64M multiply/divide sequencer for the EXE stage.
// Multiplies use radix-2 shift-add on magnitudes; divides use restoring
// shift-subtract on magnitudes. Signs are applied once, on the last iteration.
// Divide-by-zero and signed overflow finish without iterating.
module ysyx_22040759_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            ms_allowin,
    output logic            busy,
    output logic            ready_go,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Decode of the incoming operation (only meaningful while IDLE)
    // ------------------------------------------------------------------
    logic [2:0] f3_in;
    logic       is_div_in;
    logic       w_in;
    logic       sgn_in [2];
    logic [XLEN-1:0] src_raw [2];
    logic [XLEN-1:0] ext_in  [2];
    logic [XLEN-1:0] abs_in  [2];
    logic            neg_in  [2];

    assign f3_in     = op[2:0];
    assign is_div_in = op[2];
    // The W bit only exists for MUL and the divide group; MULH* ignore it.
    assign w_in      = op[3] & ((f3_in == 3'b000) | op[2]);

    // Signed divides are DIV/REM; MULHU is fully unsigned, MULHSU signs src1 only.
    assign sgn_in[0] = is_div_in ? ~f3_in[0] : (f3_in != 3'b011);
    assign sgn_in[1] = is_div_in ? ~f3_in[0] : (f3_in[1] == 1'b0);
    assign src_raw[0] = src1;
    assign src_raw[1] = src2;

    // W extension, operand sign and magnitude, identical for both sources
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        assign ext_in[gi] = w_in ? {{(XLEN-32){sgn_in[gi] & src_raw[gi][31]}}, src_raw[gi][31:0]}
                                 : src_raw[gi];
        assign neg_in[gi] = sgn_in[gi] & ext_in[gi][XLEN-1];
        assign abs_in[gi] = neg_in[gi] ? (~ext_in[gi] + 1'b1) : ext_in[gi];
    end

    // ------------------------------------------------------------------
    // Special cases resolved at acceptance
    // ------------------------------------------------------------------
    logic            div_zero_in;
    logic            div_ovf_in;
    logic [XLEN-1:0] min_neg_in;
    logic [XLEN-1:0] spec_raw_in;
    logic [XLEN-1:0] spec_res_in;

    assign min_neg_in  = w_in ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero_in = (ext_in[1] == '0);
    assign div_ovf_in  = ~f3_in[0] & (ext_in[0] == min_neg_in) & (&ext_in[1]);

    // Zero divisor: quotient all ones, remainder dividend.
    // Overflow: quotient dividend, remainder zero.
    assign spec_raw_in = f3_in[1] ? (div_zero_in ? ext_in[0] : '0)
                                  : (div_zero_in ? '1 : ext_in[0]);
    assign spec_res_in = w_in ? {{(XLEN-32){spec_raw_in[31]}}, spec_raw_in[31:0]} : spec_raw_in;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            w_q, w_d;
    logic            negq_q, negq_d;      // product / quotient sign
    logic            negr_q, negr_d;      // remainder sign
    logic [XLEN-1:0] hi_q, hi_d;          // partial product high / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;          // multiplier / dividend-quotient shift register
    logic [XLEN-1:0] opb_q, opb_d;        // multiplicand / divisor magnitude
    logic [XLEN-1:0] result_q, result_d;

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    logic [XLEN:0]   mul_add;
    logic [XLEN-1:0] mul_hi, mul_lo;
    logic [XLEN:0]   div_sh;
    logic [XLEN+1:0] div_trial;
    logic            div_ge;
    logic [XLEN-1:0] div_hi, div_lo;
    logic [XLEN-1:0] it_hi, it_lo;
    logic            unused_trial_bit;

    assign mul_add = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    assign mul_hi  = mul_add[XLEN:1];
    assign mul_lo  = {mul_add[0], lo_q[XLEN-1:1]};

    // Remainder stays below the divisor, so the bit above XLEN of a
    // successful trial subtraction is always zero.
    assign div_sh    = {hi_q, lo_q[XLEN-1]};
    assign div_trial = {1'b0, div_sh} - {2'b00, opb_q};
    assign div_ge    = ~div_trial[XLEN+1];
    assign div_hi    = div_ge ? div_trial[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_lo    = {lo_q[XLEN-2:0], div_ge};
    assign unused_trial_bit = div_trial[XLEN];

    assign it_hi = f3_q[2] ? div_hi : mul_hi;
    assign it_lo = f3_q[2] ? div_lo : mul_lo;

    // ------------------------------------------------------------------
    // Result formation from the last iteration's values
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod, prod_al, prod_s;
    logic [XLEN-1:0]   mul_res, quo, quo_s, rem_s, div_res, raw_res, fin_res;

    // A W multiply runs only 32 iterations, leaving the product 32 bits high.
    assign prod    = {it_hi, it_lo};
    assign prod_al = w_q ? (prod >> 32) : prod;
    assign prod_s  = negq_q ? (~prod_al + 1'b1) : prod_al;
    assign mul_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    // A W divide shifts the dividend in from the top, so only the low 32
    // quotient bits are produced this run.
    assign quo     = w_q ? {{(XLEN-32){1'b0}}, it_lo[31:0]} : it_lo;
    assign quo_s   = negq_q ? (~quo + 1'b1) : quo;
    assign rem_s   = negr_q ? (~it_hi + 1'b1) : it_hi;
    assign div_res = f3_q[1] ? rem_s : quo_s;

    assign raw_res = f3_q[2] ? div_res : mul_res;
    assign fin_res = w_q ? {{(XLEN-32){raw_res[31]}}, raw_res[31:0]} : raw_res;

    // ------------------------------------------------------------------
    // State register with synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            w_q      <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            w_q      <= w_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    // Next-state: accept in IDLE, iterate in CALC, hand off in DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        w_d      = w_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    f3_d   = f3_in;
                    w_d    = w_in;
                    negq_d = neg_in[0] ^ neg_in[1];
                    negr_d = neg_in[0];
                    hi_d   = '0;
                    if (is_div_in) begin
                        lo_d  = w_in ? (abs_in[0] << 32) : abs_in[0];
                        opb_d = abs_in[1];
                    end else begin
                        lo_d  = abs_in[1];
                        opb_d = abs_in[0];
                    end
                    if (is_div_in && (div_zero_in || div_ovf_in)) begin
                        result_d = spec_res_in;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = w_in ? CW'(32) : CW'(XLEN);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = it_hi;
                    lo_d  = it_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        result_d = fin_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (flush || ms_allowin) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_CALC);
    assign ready_go = (state_q == S_DONE) & ~flush;
    assign result   = result_q;

endmodule

// File: tb/tb_ysyx_22040759_mdu_ctrl.sv
// Directed bench for the multiply/divide sequencer: latency, result,
// hold under back-pressure, flush and reset behaviour.
module tb_ysyx_22040759_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [3:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        ms_allowin;
    logic        busy;
    logic        ready_go;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;

    ysyx_22040759_mdu_ctrl #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flush      (flush),
        .op         (op),
        .src1       (src1),
        .src2       (src2),
        .ms_allowin (ms_allowin),
        .busy       (busy),
        .ready_go   (ready_go),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge while IDLE. Start is presented in cycle 0;
    // exp_lat is the cycle at which ready_go first shows.
    task automatic run(input string tag, input logic [3:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input int exp_lat, input int hold);
        int k;
        int bcnt;
        op         = o;
        src1       = a;
        src2       = b;
        ms_allowin = (hold == 0);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src1  = 64'hA5A5_5A5A_DEAD_BEEF;
        src2  = 64'h0123_4567_89AB_CDEF;
        k     = 1;
        bcnt  = 0;
        while (!ready_go && k < 200) begin
            bcnt += int'(busy);
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_busy"}, 64'(bcnt), 64'(exp_lat - 1));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_rg"}, 64'(ready_go), 64'd1);
            chk({tag, "_hold_res"}, result, exp);
        end
        ms_allowin = 1'b1;
        @(negedge clk);
        chk({tag, "_idle"}, {62'd0, busy, ready_go}, 64'd0);
        $display("txn %s op=%b res=%h lat=%0d", tag, o, result, k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rg_seen;
        rst        = 1'b1;
        start      = 1'b0;
        flush      = 1'b0;
        op         = 4'b0000;
        src1       = '0;
        src2       = '0;
        ms_allowin = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {62'd0, busy, ready_go}, 64'd0);
        chk("reset_result", result, 64'd0);

        run("MUL",    4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65, 0);
        run("MULHU",  4'b0011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run("MULH",   4'b0001, '1, '1, 64'd0, 65, 0);
        run("MULHSU", 4'b0010, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run("MULH_W_ignored", 4'b1001, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 65, 0);
        run("MULW",   4'b1000, 64'h1111_1111_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
        run("DIVW",   4'b1100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run("REMW",   4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        run("DIV0",   4'b0100, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run("REMOVF", 4'b0110, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
        run("DIVOVF", 4'b0100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
        run("DIVUW0", 4'b1101, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run("REMW0",  4'b1110, 64'h1234_5678_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, 0);
        run("DIVWOVF",4'b1100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
        run("DIVU_hold", 4'b0101, 64'd100, 64'd7, 64'd14, 65, 5);

        // Flush mid-CALC, then a new operation immediately after
        op         = 4'b0000;
        src1       = 64'd3;
        src2       = 64'd5;
        ms_allowin = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        rg_seen = 1'b0;
        for (int i = 1; i < 10; i++) begin
            rg_seen |= ready_go;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {62'd0, busy, ready_go}, 64'd0);
        chk("flush_no_rg", 64'(rg_seen), 64'd0);
        $display("txn FLUSH busy=%b ready_go=%b", busy, ready_go);
        run("REMU_after_flush", 4'b0111, 64'd100, 64'd7, 64'd2, 65, 0);

        // flush and start together in IDLE: nothing accepted
        op    = 4'b0000;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_idle", {62'd0, busy, ready_go}, 64'd0);
        $display("txn FLUSH_START busy=%b ready_go=%b", busy, ready_go);

        // Reset in the middle of CALC clears everything, including result
        src1  = 64'd9;
        src2  = 64'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_state", {62'd0, busy, ready_go}, 64'd0);
        chk("rst_mid_result", result, 64'd0);
        $display("txn RESET busy=%b ready_go=%b result=%h", busy, ready_go, result);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
